clock_speed_sequencer: RTL and testbench
========================================

CLOCK_SPEED_SEQUENCER -- requirements
Module: clock_speed_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4: cycles cpu_hold is asserted before outputs change.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 16: cycles after an applied change before cpu_hold is released.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 4095: maximum cycles spent waiting for pll_srdy.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: sole clock, the reconfiguration reference clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port reg_req, input, 1 bit: one-cycle request pulse from the CPU register write.
REQ-008 The block SHALL have port reg_turbo, input, 2 bits, and port reg_pll, input, 3 bits: requested speed and video mode carried with reg_req.
REQ-009 The block SHALL have port key_req, input, 1 bit, and port key_turbo, input, 2 bits: hotkey speed request, with no PLL field.
REQ-010 The block SHALL have port pll_srdy, input, 1 bit: one-cycle PLL-ready pulse.
REQ-011 The block SHALL have port turbo_enable, output, 2 bits, and port pll_option, output, 3 bits: applied configuration.
REQ-012 The block SHALL have port cpu_hold, output, 1 bit; port busy, output, 1 bit; port done, output, 1 bit (one-cycle pulse); and port lock_error, output, 1 bit (sticky).

Function
REQ-013 FSM states SHALL be IDLE, HOLD, APPLY, WAIT_LOCK, SETTLE.
REQ-014 Each requester SHALL own a one-entry pending slot, set by its request pulse.
- A new pulse overwrites the slot's data (last-wins).
- The slot is cleared when its request is granted.
REQ-015 In IDLE, when any slot is pending, the block SHALL grant one slot and go to HOLD on the next edge.
- The key slot has priority over the reg slot.
- Grant latches the slot's data into a working register.
REQ-016 HOLD SHALL assert cpu_hold for exactly HOLD_CYCLES cycles, then enter APPLY.
REQ-017 APPLY SHALL last one cycle and update the outputs.
- turbo_enable is loaded from the working register.
- pll_option is loaded only for a reg grant.
- If pll_option changed, the next state is WAIT_LOCK; otherwise it is SETTLE.
REQ-018 WAIT_LOCK SHALL exit to SETTLE on pll_srdy.
- After LOCK_TIMEOUT cycles without pll_srdy, it SHALL set lock_error and still exit to SETTLE.
REQ-019 SETTLE SHALL last SETTLE_CYCLES cycles, then return to IDLE with done high for one cycle, in the same cycle cpu_hold falls.
REQ-020 cpu_hold SHALL be high in HOLD, APPLY, WAIT_LOCK and SETTLE.
- busy SHALL be high whenever the FSM is not IDLE or any slot is pending.
REQ-021 Requests arriving while not IDLE SHALL only update slots and SHALL NOT alter the in-progress sequence.
REQ-022 If both request pulses arrive in the same cycle in IDLE, the key request SHALL be served first and the reg request in the following sequence.
REQ-023 A request identical to the applied configuration SHALL still run HOLD and SETTLE, but SHALL skip WAIT_LOCK.
REQ-024 Counters SHALL be sized to hold the largest parameter and SHALL saturate rather than wrap.
REQ-025 pll_srdy outside WAIT_LOCK SHALL be ignored.

Reset
REQ-026 While rst is high, the block SHALL hold the following values:
- FSM in IDLE, slots and counters cleared.
- turbo_enable=2'b00 and pll_option=3'b000.
- cpu_hold, busy, done and lock_error = 0.
REQ-027 Assertion of rst mid-sequence SHALL abort immediately.
- Outputs revert to the reset values; no done pulse is issued.
- lock_error is cleared only by rst.

Verification
REQ-028 Scenario: reg_req with reg_turbo=2'b10 and reg_pll=3'b001, then pll_srdy 50 cycles after APPLY -> the bench SHALL see the following:
- cpu_hold high for 4+1+50+16 cycles.
- turbo_enable=10 and pll_option=001.
- One done pulse; lock_error stays 0.
REQ-029 Scenario: key_req with key_turbo=2'b01 -> the bench SHALL see WAIT_LOCK skipped, cpu_hold high for 4+1+16=21 cycles, pll_option unchanged, and turbo_enable=01.
REQ-030 Scenario: key_req and reg_req in the same cycle -> the bench SHALL see the key configuration applied first and the reg configuration applied in the following sequence, with two done pulses.
REQ-031 Scenario: reg request changing pll_option with pll_srdy never pulsed -> the bench SHALL see lock_error=1 after 4095 WAIT_LOCK cycles, followed by SETTLE and a done pulse.
REQ-032 Scenario: three reg_req pulses (pll 001, 010, 011) during one active sequence -> the bench SHALL see only pll_option=011 applied in the following sequence.
REQ-033 Scenario: rst asserted during WAIT_LOCK -> the bench SHALL see cpu_hold=0, turbo_enable=00, pll_option=000 and busy=0 immediately, with no done pulse.

Source files
------------

// File: rtl/clock_speed_sequencer.sv
// Sequences CPU clock-speed / PLL reconfiguration: hold CPU, apply, wait PLL lock, settle.
// Latency: grant +1, HOLD_CYCLES hold, 1 apply, 0..LOCK_TIMEOUT lock wait, SETTLE_CYCLES settle.
// Backpressure: none; requests landing mid-sequence park in one-entry last-wins slots.
module clock_speed_sequencer #(
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reg_req,
    input  logic [1:0] reg_turbo,
    input  logic [2:0] reg_pll,
    input  logic       key_req,
    input  logic [1:0] key_turbo,
    input  logic       pll_srdy,
    output logic [1:0] turbo_enable,
    output logic [2:0] pll_option,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       lock_error
);

    // One shared counter, wide enough for the largest phase length.
    localparam int MAX_HS = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int MAX_ALL = (MAX_HS > LOCK_TIMEOUT) ? MAX_HS : LOCK_TIMEOUT;
    localparam int CW = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] CNT_MAX     = CW'(MAX_ALL);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        APPLY,
        WAIT_LOCK,
        SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pending request slots
    logic       key_pend_q, key_pend_d;
    logic [1:0] key_turbo_q, key_turbo_d;
    logic       reg_pend_q, reg_pend_d;
    logic [1:0] reg_turbo_q, reg_turbo_d;
    logic [2:0] reg_pll_q, reg_pll_d;

    // Working copy of the granted request
    logic [1:0] wrk_turbo_q, wrk_turbo_d;
    logic [2:0] wrk_pll_q, wrk_pll_d;
    logic       wrk_is_reg_q, wrk_is_reg_d;

    // Applied configuration and status
    logic [1:0] turbo_q, turbo_d;
    logic [2:0] pll_q, pll_d;
    logic       done_q, done_d;
    logic       lock_err_q, lock_err_d;

    logic grant_key, grant_reg;

    // Next-state, slot bookkeeping and output register loads
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        key_pend_d   = key_pend_q;
        key_turbo_d  = key_turbo_q;
        reg_pend_d   = reg_pend_q;
        reg_turbo_d  = reg_turbo_q;
        reg_pll_d    = reg_pll_q;
        wrk_turbo_d  = wrk_turbo_q;
        wrk_pll_d    = wrk_pll_q;
        wrk_is_reg_d = wrk_is_reg_q;
        turbo_d      = turbo_q;
        pll_d        = pll_q;
        done_d       = 1'b0;
        lock_err_d   = lock_err_q;
        grant_key    = 1'b0;
        grant_reg    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Hotkey wins over the register path when both are waiting.
                if (key_pend_q) begin
                    grant_key    = 1'b1;
                    wrk_turbo_d  = key_turbo_q;
                    wrk_is_reg_d = 1'b0;
                    state_d      = HOLD;
                end else if (reg_pend_q) begin
                    grant_reg    = 1'b1;
                    wrk_turbo_d  = reg_turbo_q;
                    wrk_pll_d    = reg_pll_q;
                    wrk_is_reg_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = APPLY;
                    cnt_d   = '0;
                end
            end
            APPLY: begin
                cnt_d   = '0;
                turbo_d = wrk_turbo_q;
                // Hotkey requests carry no PLL field, so they never relock.
                if (wrk_is_reg_q) begin
                    pll_d = wrk_pll_q;
                end
                if (wrk_is_reg_q && (wrk_pll_q != pll_q)) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = SETTLE;
                end
            end
            WAIT_LOCK: begin
                if (pll_srdy) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    // Give up on the lock but still let the CPU run again.
                    lock_err_d = 1'b1;
                    state_d    = SETTLE;
                    cnt_d      = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A grant empties its slot; a fresh pulse in the same cycle refills it.
        if (grant_key) begin
            key_pend_d = 1'b0;
        end
        if (grant_reg) begin
            reg_pend_d = 1'b0;
        end
        if (key_req) begin
            key_pend_d  = 1'b1;
            key_turbo_d = key_turbo;
        end
        if (reg_req) begin
            reg_pend_d  = 1'b1;
            reg_turbo_d = reg_turbo;
            reg_pll_d   = reg_pll;
        end
    end

    // State and data registers; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_pend_q   <= 1'b0;
            key_turbo_q  <= 2'b00;
            reg_pend_q   <= 1'b0;
            reg_turbo_q  <= 2'b00;
            reg_pll_q    <= 3'b000;
            wrk_turbo_q  <= 2'b00;
            wrk_pll_q    <= 3'b000;
            wrk_is_reg_q <= 1'b0;
            turbo_q      <= 2'b00;
            pll_q        <= 3'b000;
            done_q       <= 1'b0;
            lock_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_pend_q   <= key_pend_d;
            key_turbo_q  <= key_turbo_d;
            reg_pend_q   <= reg_pend_d;
            reg_turbo_q  <= reg_turbo_d;
            reg_pll_q    <= reg_pll_d;
            wrk_turbo_q  <= wrk_turbo_d;
            wrk_pll_q    <= wrk_pll_d;
            wrk_is_reg_q <= wrk_is_reg_d;
            turbo_q      <= turbo_d;
            pll_q        <= pll_d;
            done_q       <= done_d;
            lock_err_q   <= lock_err_d;
        end
    end

    assign turbo_enable = turbo_q;
    assign pll_option   = pll_q;
    assign cpu_hold     = (state_q != IDLE);
    assign busy         = (state_q != IDLE) | key_pend_q | reg_pend_q;
    assign done         = done_q;
    assign lock_error   = lock_err_q;

endmodule

// File: tb/tb_clock_speed_sequencer.sv
// Randomized and directed bench for clock_speed_sequencer against a timeline reference model.
// Latency: checks every cycle on the falling edge; inputs change on the falling edge.
// Backpressure: n/a; every wait on the DUT is bounded by a cycle budget.
module tb_clock_speed_sequencer;

    localparam int HOLD   = 4;
    localparam int SETTLE = 16;
    localparam int LOCK   = 4095;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reg_req = 1'b0;
    logic [1:0] reg_turbo = 2'b00;
    logic [2:0] reg_pll = 3'b000;
    logic       key_req = 1'b0;
    logic [1:0] key_turbo = 2'b00;
    logic       pll_srdy = 1'b0;
    logic [1:0] turbo_enable;
    logic [2:0] pll_option;
    logic       cpu_hold, busy, done, lock_error;

    clock_speed_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .SETTLE_CYCLES(SETTLE),
        .LOCK_TIMEOUT (LOCK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_req     (reg_req),
        .reg_turbo   (reg_turbo),
        .reg_pll     (reg_pll),
        .key_req     (key_req),
        .key_turbo   (key_turbo),
        .pll_srdy    (pll_srdy),
        .turbo_enable(turbo_enable),
        .pll_option  (pll_option),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .lock_error  (lock_error)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference model: pending slots plus absolute cycle deadlines of the active sequence.
    int         m_cyc = 0;
    bit         m_seq, m_waiting, m_done, m_lerr;
    int         m_t_apply, m_t_release;
    bit         m_kp, m_rp, m_wreg;
    logic [1:0] m_kt, m_rt, m_wt, m_turbo;
    logic [2:0] m_rpl, m_wp, m_pll;

    // Observations of the DUT, used for per-sequence checks
    int         hold_run = 0;
    int         last_hold_len = 0;
    int         done_cnt = 0;
    logic [1:0] done_turbo[$];
    logic [2:0] done_pll[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seq = 0; m_waiting = 0; m_done = 0; m_lerr = 0;
        m_t_apply = 0; m_t_release = -1;
        m_kp = 0; m_rp = 0; m_wreg = 0;
        m_kt = 0; m_rt = 0; m_wt = 0; m_turbo = 0;
        m_rpl = 0; m_wp = 0; m_pll = 0;
        hold_run = 0;
    endtask

    // Advance the model across one rising edge given that cycle's inputs.
    task automatic model_step(input bit kr, input logic [1:0] kt, input bit rr,
                              input logic [1:0] rt, input logic [2:0] rp, input bit sr);
        int n = m_cyc;
        bit g_key = 0, g_reg = 0;
        m_done = 0;
        if (!m_seq) begin
            if (m_kp) begin
                g_key = 1; m_wt = m_kt; m_wreg = 0;
            end else if (m_rp) begin
                g_reg = 1; m_wt = m_rt; m_wp = m_rpl; m_wreg = 1;
            end
            if (g_key || g_reg) begin
                m_seq = 1; m_t_apply = n + 1 + HOLD; m_t_release = -1; m_waiting = 0;
            end
        end else if (n == m_t_apply) begin
            bit relock = m_wreg && (m_wp != m_pll);
            m_turbo = m_wt;
            if (m_wreg) m_pll = m_wp;
            if (relock) m_waiting = 1;
            else m_t_release = n + 1 + SETTLE;
        end else if (m_waiting) begin
            if (sr || (n - m_t_apply == LOCK)) begin
                if (!sr) m_lerr = 1;
                m_waiting = 0;
                m_t_release = n + 1 + SETTLE;
            end
        end else if (n + 1 == m_t_release) begin
            m_seq = 0;
            m_done = 1;
        end
        if (g_key) m_kp = 0;
        if (g_reg) m_rp = 0;
        if (kr) begin m_kp = 1; m_kt = kt; end
        if (rr) begin m_rp = 1; m_rt = rt; m_rpl = rp; end
        m_cyc++;
    endtask

    task automatic check_outputs();
        chk("cpu_hold", cpu_hold, m_seq);
        chk("busy", busy, m_seq | m_kp | m_rp);
        chk("done", done, m_done);
        chk("turbo_enable", turbo_enable, m_turbo);
        chk("pll_option", pll_option, m_pll);
        chk("lock_error", lock_error, m_lerr);
        if (done) begin
            done_cnt++;
            last_hold_len = hold_run;
            hold_run = 0;
            done_turbo.push_back(turbo_enable);
            done_pll.push_back(pll_option);
        end
        if (cpu_hold) hold_run++;
    endtask

    task automatic cyc(input bit kr, input logic [1:0] kt, input bit rr,
                       input logic [1:0] rt, input logic [2:0] rp, input bit sr);
        @(negedge clk);
        check_outputs();
        key_req = kr; key_turbo = kt;
        reg_req = rr; reg_turbo = rt; reg_pll = rp;
        pll_srdy = sr;
        @(posedge clk);
        model_step(kr, kt, rr, rt, rp, sr);
    endtask

    // Run until nothing is active or pending, then one more cycle to see done.
    // srdy_dly < 0 means the PLL never reports ready.
    task automatic drain(input int srdy_dly, input int limit);
        bit idle_reached = 0;
        for (int i = 0; i < limit; i++) begin
            bit sr;
            if (!m_seq && !m_kp && !m_rp) begin
                idle_reached = 1;
                break;
            end
            sr = (srdy_dly >= 0) && m_waiting && (m_cyc >= m_t_apply + srdy_dly);
            cyc(0, 2'b00, 0, 2'b00, 3'b000, sr);
        end
        chk("drain_reached_idle", idle_reached, 1);
        cyc(0, 2'b00, 0, 2'b00, 3'b000, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int idx;
        model_reset();

        // Reset values while rst is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Reg request with PLL change, srdy 50 cycles after APPLY
        d0 = done_cnt;
        cyc(0, 2'b00, 1, 2'b10, 3'b001, 0);
        drain(50, 500);
        chk("s1_hold_len", last_hold_len, 4 + 1 + 50 + 16);
        chk("s1_done_cnt", done_cnt - d0, 1);
        chk("s1_turbo", turbo_enable, 2'b10);
        chk("s1_pll", pll_option, 3'b001);
        chk("s1_lock_error", lock_error, 0);

        // Hotkey request: no PLL field, WAIT_LOCK skipped
        d0 = done_cnt;
        cyc(1, 2'b01, 0, 2'b00, 3'b000, 0);
        drain(-1, 200);
        chk("s2_hold_len", last_hold_len, 21);
        chk("s2_done_cnt", done_cnt - d0, 1);
        chk("s2_turbo", turbo_enable, 2'b01);
        chk("s2_pll", pll_option, 3'b001);

        // Both requesters in the same cycle: key first, then reg
        d0 = done_cnt;
        idx = done_turbo.size();
        cyc(1, 2'b11, 1, 2'b00, 3'b100, 0);
        drain(7, 500);
        chk("s3_done_cnt", done_cnt - d0, 2);
        chk("s3_first_turbo", done_turbo[idx], 2'b11);
        chk("s3_first_pll", done_pll[idx], 3'b001);
        chk("s3_second_turbo", done_turbo[idx + 1], 2'b00);
        chk("s3_second_pll", done_pll[idx + 1], 3'b100);
        chk("s3_second_hold_len", last_hold_len, 4 + 1 + 7 + 16);

        // PLL never locks: timeout sets sticky lock_error
        d0 = done_cnt;
        cyc(0, 2'b00, 1, 2'b01, 3'b110, 0);
        drain(-1, 5000);
        chk("s4_done_cnt", done_cnt - d0, 1);
        chk("s4_hold_len", last_hold_len, 4 + 1 + LOCK + 16);
        chk("s4_lock_error", lock_error, 1);
        chk("s4_pll", pll_option, 3'b110);

        // Three reg pulses during one active sequence: last one wins
        d0 = done_cnt;
        idx = done_pll.size();
        cyc(1, 2'b10, 0, 2'b00, 3'b000, 0);
        cyc(0, 2'b00, 0, 2'b00, 3'b000, 0);
        cyc(0, 2'b00, 1, 2'b11, 3'b001, 0);
        cyc(0, 2'b00, 0, 2'b00, 3'b000, 0);
        cyc(0, 2'b00, 1, 2'b11, 3'b010, 0);
        cyc(0, 2'b00, 1, 2'b11, 3'b011, 0);
        drain(5, 500);
        chk("s5_done_cnt", done_cnt - d0, 2);
        chk("s5_first_pll", done_pll[idx], 3'b110);
        chk("s5_second_pll", done_pll[idx + 1], 3'b011);
        chk("s5_turbo", turbo_enable, 2'b11);
        chk("s5_lock_error_sticky", lock_error, 1);

        // Random traffic, including srdy pulses outside WAIT_LOCK
        for (int i = 0; i < 600; i++) begin
            bit kr = ($urandom_range(0, 19) == 0);
            bit rr = ($urandom_range(0, 19) == 0);
            bit sr = ($urandom_range(0, 5) == 0);
            logic [1:0] kt = 2'($urandom_range(0, 3));
            logic [1:0] rt = 2'($urandom_range(0, 3));
            logic [2:0] rp = 3'($urandom_range(0, 7));
            cyc(kr, kt, rr, rt, rp, sr);
        end
        drain(4, 6000);

        // Reset during WAIT_LOCK aborts immediately with no done
        cyc(0, 2'b00, 1, 2'b11, (pll_option == 3'b101) ? 3'b010 : 3'b101, 0);
        for (int i = 0; i < 100; i++) begin
            if (m_waiting && (m_cyc > m_t_apply + 5)) break;
            cyc(0, 2'b00, 0, 2'b00, 3'b000, 0);
        end
        chk("s6_in_wait_lock", cpu_hold, 1);
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("s6_cpu_hold", cpu_hold, 0);
        chk("s6_turbo", turbo_enable, 2'b00);
        chk("s6_pll", pll_option, 3'b000);
        chk("s6_busy", busy, 0);
        chk("s6_lock_error", lock_error, 0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b0;
        repeat (20) cyc(0, 2'b00, 0, 2'b00, 3'b000, 0);
        chk("s6_no_done", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
